// File: rtl/dual_jk_sequencer.sv
// Dual JK flip-flop sequencer: drives J/K/CP/R of two external
// negative-edge JK flops to a requested pattern, then compares the
// fed-back Q outputs with the modelled state and latches a sticky error.
module dual_jk_sequencer #(
    parameter int JK_LAW     = 1,
    parameter int RST_CYCLES = 2,
    parameter int SETTLE     = 1
) (
    input  logic       CP,
    input  logic       R,
    input  logic       req_valid,
    input  logic [1:0] req_q,
    input  logic       req_clear,
    output logic       req_ready,
    output logic       J1,
    output logic       K1,
    output logic       CP1,
    output logic       R1,
    output logic       J2,
    output logic       K2,
    output logic       CP2,
    output logic       R2,
    input  logic       Q1,
    input  logic       Q2,
    output logic [1:0] exp_q,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SETUP = 3'd2,
        ST_CPHI  = 3'd3,
        ST_CPLO  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_CHECK = 3'd6
    } state_t;

    localparam logic [3:0] RST_LOAD    = 4'(RST_CYCLES - 1);
    localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic       SETTLE_NONE = (SETTLE == 0) ? 1'b1 : 1'b0;

    // Excitation {J,K} that moves a flop from e to t under the device law;
    // the non-steering input is always held at 0.
    function automatic logic [1:0] excite_jk(input logic e, input logic t);
        logic j_s;
        logic k_s;
        j_s = ~e & t;
        if (JK_LAW == 1) begin
            k_s = e & t;
        end else begin
            k_s = e & ~t;
        end
        return {j_s, k_s};
    endfunction

    state_t     state_r,  state_nxt_s;
    logic [3:0] cnt_r,    cnt_nxt_s;
    logic [1:0] target_r, target_nxt_s;
    logic [1:0] exp_q_r,  exp_nxt_s;
    logic       err_r,    err_nxt_s;
    logic       boot_r,   boot_nxt_s;
    logic [3:0] jk_r,     jk_nxt_s;      // {J2,K2,J1,K1}
    logic       ready_r,  ready_nxt_s;
    logic       cp_r,     cp_nxt_s;
    logic       rn_r,     rn_nxt_s;
    logic       done_r,   done_nxt_s;

    // Next-state, model-state and next-output decode.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        target_nxt_s = target_r;
        exp_nxt_s    = exp_q_r;
        err_nxt_s    = err_r;
        boot_nxt_s   = boot_r;
        jk_nxt_s     = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                if (boot_r) begin
                    state_nxt_s = ST_CLR;
                    cnt_nxt_s   = RST_LOAD;
                    boot_nxt_s  = 1'b0;
                end else if (ready_r && req_clear) begin
                    state_nxt_s = ST_CLR;
                    cnt_nxt_s   = RST_LOAD;
                    err_nxt_s   = 1'b0;
                end else if (ready_r && req_valid) begin
                    state_nxt_s  = ST_SETUP;
                    target_nxt_s = req_q;
                    jk_nxt_s     = {excite_jk(exp_q_r[1], req_q[1]),
                                    excite_jk(exp_q_r[0], req_q[0])};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLR: begin
                if (cnt_r == 4'd0) begin
                    exp_nxt_s = 2'b00;
                    if (SETTLE_NONE) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = SETTLE_LOAD;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_CPHI;
                jk_nxt_s    = jk_r;
            end
            ST_CPHI: begin
                state_nxt_s = ST_CPLO;
                jk_nxt_s    = jk_r;
            end
            ST_CPLO: begin
                exp_nxt_s = target_r;
                if (SETTLE_NONE) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = SETTLE_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_CHECK: begin
                if ({Q2, Q1} != exp_q_r) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        ready_nxt_s = (state_nxt_s == ST_IDLE) && !boot_nxt_s;
        cp_nxt_s    = (state_nxt_s == ST_CPHI);
        rn_nxt_s    = (state_nxt_s != ST_CLR);
        done_nxt_s  = (state_nxt_s == ST_CHECK);
    end

    // State and registered outputs; R forces the quiescent reset image.
    always_ff @(posedge CP) begin
        if (R) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            target_r <= 2'b00;
            exp_q_r  <= 2'b00;
            err_r    <= 1'b0;
            boot_r   <= 1'b1;
            jk_r     <= 4'b0000;
            ready_r  <= 1'b0;
            cp_r     <= 1'b0;
            rn_r     <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            target_r <= target_nxt_s;
            exp_q_r  <= exp_nxt_s;
            err_r    <= err_nxt_s;
            boot_r   <= boot_nxt_s;
            jk_r     <= jk_nxt_s;
            ready_r  <= ready_nxt_s;
            cp_r     <= cp_nxt_s;
            rn_r     <= rn_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign req_ready = ready_r;
    assign J2        = jk_r[3];
    assign K2        = jk_r[2];
    assign J1        = jk_r[1];
    assign K1        = jk_r[0];
    assign CP1       = cp_r;
    assign CP2       = cp_r;
    assign R1        = rn_r;
    assign R2        = rn_r;
    assign exp_q     = exp_q_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_dual_jk_sequencer.sv
// Scoreboard bench for dual_jk_sequencer with a behavioural JK device model.
module tb_dual_jk_sequencer;

    localparam int JK_LAW     = 1;
    localparam int RST_CYCLES = 2;
    localparam int SETTLE     = 1;
    localparam int LOAD_LAT   = 4 + SETTLE;
    localparam int CLR_LAT    = RST_CYCLES + SETTLE + 1;

    logic       CP = 1'b0;
    logic       R = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_q = 2'b00;
    logic       req_clear = 1'b0;
    logic       req_ready;
    logic       J1, K1, CP1, R1, J2, K2, CP2, R2;
    logic       Q1, Q2;
    logic [1:0] exp_q;
    logic       done, err;

    dual_jk_sequencer #(.JK_LAW(JK_LAW), .RST_CYCLES(RST_CYCLES), .SETTLE(SETTLE)) dut (
        .CP(CP), .R(R), .req_valid(req_valid), .req_q(req_q), .req_clear(req_clear),
        .req_ready(req_ready), .J1(J1), .K1(K1), .CP1(CP1), .R1(R1),
        .J2(J2), .K2(K2), .CP2(CP2), .R2(R2), .Q1(Q1), .Q2(Q2),
        .exp_q(exp_q), .done(done), .err(err)
    );

    always #5 CP = ~CP;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge CP) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- device model: two negative-edge JK flops ----------------
    logic       dq1 = 1'b0;
    logic       dq2 = 1'b0;
    logic       force_en = 1'b0;
    logic [1:0] force_val = 2'b00;

    function automatic logic dev_next(input logic q, input logic j, input logic k);
        if (JK_LAW == 1) return (j & ~q) | (k & q);
        else             return (j & ~q) | (~k & q);
    endfunction

    always @(negedge CP1 or negedge R1) begin
        if (!R1) dq1 <= 1'b0;
        else     dq1 <= dev_next(dq1, J1, K1);
    end
    always @(negedge CP2 or negedge R2) begin
        if (!R2) dq2 <= 1'b0;
        else     dq2 <= dev_next(dq2, J2, K2);
    end
    assign Q1 = force_en ? force_val[0] : dq1;
    assign Q2 = force_en ? force_val[1] : dq2;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic       is_clear;
        logic [1:0] exp;
        logic       err;
        logic [3:0] jk;
        int         lat;
        int         acc;
    } item_t;

    item_t sb_q[$];

    // Excitation table written out case by case: returns {J,K}.
    function automatic logic [1:0] jk_table(input logic e, input logic t);
        case ({e, t})
            2'b00:   return 2'b00;
            2'b01:   return 2'b10;
            2'b10:   return (JK_LAW == 1) ? 2'b00 : 2'b01;
            2'b11:   return (JK_LAW == 1) ? 2'b01 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    logic [1:0] m_exp = 2'b00;
    logic       m_err = 1'b0;
    logic       boot_pending = 1'b1;

    // Issue side: spot accepted requests and push the modelled outcome.
    always @(negedge CP) begin
        item_t it;
        if (R) begin
            boot_pending = 1'b1;
            m_exp = 2'b00;
            m_err = 1'b0;
            sb_q.delete();
        end else if (boot_pending || (req_ready && (req_clear || req_valid))) begin
            it.acc = cyc;
            if (boot_pending || req_clear) begin
                it.is_clear = 1'b1;
                it.exp = 2'b00;
                it.jk = 4'b0000;
                it.lat = CLR_LAT;
                it.err = force_en && (force_val != 2'b00);
            end else begin
                it.is_clear = 1'b0;
                it.exp = req_q;
                it.jk = {jk_table(m_exp[1], req_q[1]), jk_table(m_exp[0], req_q[0])};
                it.lat = LOAD_LAT;
                it.err = m_err | (force_en && (force_val != req_q));
            end
            boot_pending = 1'b0;
            m_exp = it.exp;
            m_err = it.err;
            sb_q.push_back(it);
        end
    end

    // Monitor: reset image, per-operation pulse counts, done-driven compares.
    logic r_prev = 1'b0;
    int   cp_cnt = 0;
    int   rl_cnt = 0;
    logic err_pend = 1'b0;
    logic err_pend_val = 1'b0;

    always @(negedge CP) begin
        item_t it;
        if (R) begin
            if (r_prev) begin
                check("reset_outputs",
                      {J1, K1, J2, K2, CP1, CP2, R1, R2, done, err, req_ready, exp_q}, 32'd0);
            end
            cp_cnt = 0;
            rl_cnt = 0;
            err_pend = 1'b0;
        end else begin
            if (err_pend) begin
                check("err_after_check", err, err_pend_val);
                err_pend = 1'b0;
            end
            if (!r_prev) begin
                if (CP1) cp_cnt++;
                if (!R1) rl_cnt++;
            end
            check("pair_lockstep", {CP1, R1}, {CP2, R2});
            if (CP1 && sb_q.size() > 0 && !sb_q[0].is_clear) begin
                check("jk_during_cp", {J2, K2, J1, K1}, sb_q[0].jk);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    check("exp_q", exp_q, it.exp);
                    check("latency", cyc - it.acc, it.lat);
                    check("cp_pulses", cp_cnt, it.is_clear ? 0 : 1);
                    check("reset_cycles", rl_cnt, it.is_clear ? RST_CYCLES : 0);
                    err_pend = 1'b1;
                    err_pend_val = it.err;
                end
                cp_cnt = 0;
                rl_cnt = 0;
            end
        end
        r_prev = R;
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge CP);
            if (req_ready) seen = 1'b1;
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic clr, input logic vld, input logic [1:0] q,
                         input logic fen, input logic [1:0] fval);
        wait_ready();
        @(posedge CP);
        #1;
        req_clear = clr;
        req_valid = vld;
        req_q = q;
        force_en = fen;
        force_val = fval;
        @(posedge CP);
        #1;
        req_clear = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge CP);
        #1 R = 1'b0;

        do_op(1'b0, 1'b1, 2'b11, 1'b0, 2'b00);   // 00 -> 11
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);   // 11 -> 01
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);   // same target still pulses
        do_op(1'b1, 1'b1, 2'b10, 1'b0, 2'b00);   // clear wins over load
        do_op(1'b0, 1'b1, 2'b10, 1'b1, 2'b00);   // feedback stuck -> err
        do_op(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);   // err stays over a load
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);   // clear drops err
        do_op(1'b0, 1'b1, 2'b11, 1'b1, 2'b01);   // err again before abort

        // Abort during CP high: reset lands next edge, then a full clear runs.
        wait_ready();
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CP);
            if (CP1) seen = 1'b1;
        end
        check("cp_high_seen", seen, 1'b1);
        #2 R = 1'b1;
        @(posedge CP);
        #1;
        check("abort_image", {CP1, R1, R2, err, done}, 5'b00000);
        repeat (2) @(posedge CP);
        #1 R = 1'b0;

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) @(posedge CP);
            do_op(kind < 2, kind != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)));
        end

        wait_ready();
        repeat (3) @(negedge CP);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_jk_sequencer.md
DUAL_JK_SEQUENCER -- requirements
Module: dual_jk_sequencer

Interface
REQ-001 SHALL provide parameter JK_LAW, default 1: excitation law of driven device. 1 = Q+ = J·/Q + K·Q; 0 = Q+ = J·/Q + /K·Q.
REQ-002 SHALL provide parameter RST_CYCLES, default 2: cycles device reset is held low per clear, range 1..15.
REQ-003 SHALL provide parameter SETTLE, default 1: cycles between CP falling and Q check, range 0..7.
REQ-004 SHALL have ports, one per line:
  CP         in   1  system clock, all state on rising edge
  R          in   1  reset, synchronous, active-high
  req_valid  in   1  request to load target pattern
  req_q      in   2  target pattern, bit0 = FF1, bit1 = FF2
  req_clear  in   1  request to clear device (pulse R1/R2)
  req_ready  out  1  sequencer idle, request accepted this cycle if valid
  J1, K1     out  1  FF1 excitation
  CP1        out  1  FF1 clock, negative-edge sampled by device
  R1         out  1  FF1 reset, active-low
  J2, K2, CP2, R2  out  1  same for FF2
  Q1, Q2     in   1  device outputs fed back
  exp_q      out  2  modelled device state
  done       out  1  one-cycle pulse, operation complete
  err        out  1  sticky mismatch flag
REQ-005 Clock is CP. Reset is R, synchronous, active-high. No other clock or asynchronous path.

Function
REQ-006 FSM states: IDLE, CLR, SETUP, CPHI, CPLO, WAIT, CHECK. All outputs registered.
REQ-007 req_ready SHALL be 1 only in IDLE. Acceptance = req_valid|req_clear sampled high with req_ready=1.
REQ-008 req_clear and req_valid both high at acceptance: clear wins, req_valid ignored, no load queued.
REQ-009 Clear: IDLE->CLR. R1=R2=0 for exactly RST_CYCLES cycles, CP1=CP2=0, J/K=0. Then R1=R2=1, exp_q=2'b00, go to WAIT.
REQ-010 Load: IDLE->SETUP, target latched from req_q. SETUP (1 cycle): J/K driven per REQ-011, CP1=CP2=0.
REQ-011 Excitation per flop, from exp_q bit e and target t:
  JK_LAW=1: e=0: J=t, K=0. e=1: J=0, K=t.
  JK_LAW=0: e=0: J=t, K=0. e=1: J=0, K=~t.
REQ-012 CPHI (1 cycle): CP1=CP2=1, J/K held. CPLO (1 cycle): CP1=CP2=0 (falling edge = device sample point), J/K held. exp_q <= target at leaving CPLO.
REQ-013 Both flops SHALL be pulsed on every load, including when target equals exp_q.
REQ-014 J/K SHALL NOT change in SETUP, CPHI or CPLO. J/K return to 0 on entry to WAIT.
REQ-015 WAIT lasts SETTLE cycles (0 = pass straight through to CHECK). Then CHECK.
REQ-016 CHECK (1 cycle): done=1. If {Q2,Q1} != exp_q, err set at end of CHECK. Next state IDLE.
REQ-017 err sticky: cleared only by R or by an accepted clear. Never cleared by a load.
REQ-018 Request inputs ignored outside IDLE; no buffering.
REQ-019 Outside CLR, R1=R2=1. Outside CPHI, CP1=CP2=0.
REQ-020 Load latency, accept to done: 4 + SETTLE cycles. Clear latency: RST_CYCLES + SETTLE + 1 cycles.

Reset
REQ-021 While R=1: state IDLE, J1=K1=J2=K2=0, CP1=CP2=0, R1=R2=0, exp_q=0, done=0, err=0, req_ready=0.
REQ-022 First cycle after R falls: enter CLR; full clear sequence per REQ-009 before first IDLE.
REQ-023 R mid-operation: abort immediately, next cycle all outputs per REQ-021; partial CP pulse discarded.

Verification
REQ-024 After reset release: R1=R2=0 for 2 cycles, then done pulse, exp_q=00, err=0, req_ready=1.
REQ-025 JK_LAW=1, exp_q=00, load req_q=11: SETUP J1=J2=1, K=0; CP high 1 cycle; done 5 cycles after accept; exp_q=11; Q fed back 11 -> err=0.
REQ-026 JK_LAW=1, exp_q=11, load 01: J1=0,K1=1; J2=0,K2=0; exp_q=01. JK_LAW=0 same case: K1=0, K2=1.
REQ-027 req_valid=1, req_q=10 and req_clear=1 same cycle: only clear runs, exp_q=00, no CP pulse.
REQ-028 Feedback forced 00 after load 10: err=1 at CHECK; stays 1 over following load 00; cleared by req_clear.
REQ-029 R asserted during CPHI: next cycle CP1=0, R1=R2=0, err=0; after release full clear runs.
